// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer for the rate-1/2 convolutional encoder.
// Accepts payload bytes over valid/ready, serialises them MSB-first onto the
// encoder input, appends TAIL zero bits, and registers the encoder's symbol
// pairs into a framed output stream (out_valid / out_last / done).
module conv_enc_frame_ctrl #(
    parameter int LEN_W = 12,
    parameter int TAIL  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    output logic             busy,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             enc_in_bit,
    input  logic [1:0]       enc_sym,
    output logic [1:0]       out_sym,
    output logic             out_valid,
    output logic             out_last,
    output logic             done,
    output logic             underrun
);

    // Tail counter covers the TAIL zero bits plus two drain cycles, so that
    // done lands exactly one cycle after the registered out_last.
    localparam int TC_W = $clog2(TAIL + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DATA,
        S_TAIL,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bytes_acc_q;
    logic [LEN_W-1:0] bytes_sent_q;
    logic [2:0]       bit_cnt_q;
    logic [TC_W-1:0]  tail_cnt_q;
    logic [7:0]       shift_q;
    logic [7:0]       hold_q;
    logic             hold_full_q;
    logic             enc_bit_q;
    logic             bit_vld_q;
    logic             last_bit_q;
    logic [1:0]       out_sym_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic             done_q;
    logic             busy_q;
    logic             underrun_q;
    logic             in_ready_d;
    logic             accept_d;

    // Byte acceptance: only while framing, with the hold register free and
    // the frame's byte budget not yet exhausted.
    always_comb begin
        in_ready_d = ((state_q == S_LOAD) || (state_q == S_DATA)) &&
                     !hold_full_q && (bytes_acc_q < len_q);
        accept_d   = in_valid && in_ready_d;
    end

    // Frame FSM, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            bytes_acc_q  <= '0;
            bytes_sent_q <= '0;
            bit_cnt_q    <= '0;
            tail_cnt_q   <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            enc_bit_q    <= 1'b0;
            bit_vld_q    <= 1'b0;
            last_bit_q   <= 1'b0;
            out_sym_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            out_sym_q   <= enc_sym;
            out_valid_q <= bit_vld_q;
            out_last_q  <= last_bit_q;
            enc_bit_q   <= 1'b0;
            bit_vld_q   <= 1'b0;
            last_bit_q  <= 1'b0;
            done_q      <= 1'b0;

            if (accept_d) begin
                hold_q      <= in_data;
                hold_full_q <= 1'b1;
                bytes_acc_q <= bytes_acc_q + LEN_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (start && (frame_len != '0)) begin
                        len_q        <= frame_len;
                        underrun_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        bytes_acc_q  <= '0;
                        bytes_sent_q <= '0;
                        hold_full_q  <= 1'b0;
                        bit_cnt_q    <= '0;
                        tail_cnt_q   <= '0;
                        state_q      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (hold_full_q) begin
                        shift_q      <= hold_q;
                        hold_full_q  <= 1'b0;
                        bytes_sent_q <= bytes_sent_q + LEN_W'(1);
                        bit_cnt_q    <= '0;
                        state_q      <= S_DATA;
                    end
                end
                S_DATA: begin
                    enc_bit_q <= shift_q[7];
                    bit_vld_q <= 1'b1;
                    shift_q   <= {shift_q[6:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (bytes_sent_q == len_q) begin
                            tail_cnt_q <= '0;
                            state_q    <= S_TAIL;
                        end else if (hold_full_q) begin
                            shift_q      <= hold_q;
                            hold_full_q  <= 1'b0;
                            bytes_sent_q <= bytes_sent_q + LEN_W'(1);
                        end else begin
                            underrun_q <= 1'b1;
                            tail_cnt_q <= '0;
                            state_q    <= S_TAIL;
                        end
                    end
                end
                S_TAIL: begin
                    tail_cnt_q <= tail_cnt_q + TC_W'(1);
                    if (tail_cnt_q < TC_W'(TAIL)) begin
                        bit_vld_q <= 1'b1;
                        if (tail_cnt_q == TC_W'(TAIL - 1)) begin
                            last_bit_q <= 1'b1;
                        end
                    end else if (tail_cnt_q == TC_W'(TAIL + 1)) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign in_ready   = in_ready_d;
    assign enc_in_bit = enc_bit_q;
    assign out_sym    = out_sym_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign done       = done_q;
    assign underrun   = underrun_q;

endmodule
